// File: rtl/mest_pro_run_ctrl.sv
// Run controller for a core under test: sequences memory/core reset and start, then checks each
// returned result against a preloaded table. Control/status outputs are registered (one cycle after the causing edge); no backpressure.
module mest_pro_run_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int RESULT_DEPTH    = 256,
  parameter int MEM_RST_CYCLES  = 1,
  parameter int CORE_RST_CYCLES = 10,
  parameter int START_DELAY     = 10,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int IDX_W          = $clog2(RESULT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_go,
  input  logic                  i_exp_wr,
  input  logic [IDX_W-1:0]      i_exp_addr,
  input  logic [DATA_WIDTH+1:0] i_exp_data,
  input  logic [IDX_W:0]        i_exp_count,
  output logic                  o_memory_reset,
  output logic                  o_core_reset_n,
  output logic                  o_start,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_valid_result,
  input  logic                  i_carry,
  input  logic                  i_zero_flag,
  input  logic                  i_all_done,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic                  o_overflow,
  output logic [IDX_W:0]        o_result_count,
  output logic [IDX_W:0]        o_mismatch_count,
  output logic [IDX_W:0]        o_first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_RST, S_CORE_RST, S_WAIT, S_START, S_RUN, S_DONE
  } state_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(RESULT_DEPTH);

  state_t                state_q;
  logic [31:0]           cnt_q, wdog_q;
  logic                  mem_rst_q, core_rst_n_q, start_q;
  logic                  busy_q, done_q, pass_q, timeout_q, ovf_q, fail_seen_q;
  logic [IDX_W:0]        res_cnt_q, mis_cnt_q, ffi_q, exp_cnt_q;
  logic [DATA_WIDTH+1:0] tbl [RESULT_DEPTH];

  logic [DATA_WIDTH+1:0] obs, exp_entry;
  logic                  ovf_hit, mis, ovf_d, pass_d;
  logic [IDX_W:0]        res_cnt_d, mis_cnt_d;

  // Table survives reset so a run can be repeated without reloading.
  always_ff @(posedge clk) begin
    if (i_exp_wr) tbl[i_exp_addr] <= i_exp_data;
  end

  always_comb begin
    obs       = {i_carry, i_zero_flag, i_result};
    exp_entry = tbl[res_cnt_q[IDX_W-1:0]];
    ovf_hit   = (res_cnt_q >= DEPTH_L) || (res_cnt_q >= exp_cnt_q);
    mis       = ovf_hit || (obs != exp_entry);
    res_cnt_d = res_cnt_q;
    mis_cnt_d = mis_cnt_q;
    ovf_d     = ovf_q;
    if (i_valid_result) begin
      res_cnt_d = (res_cnt_q == '1) ? res_cnt_q : res_cnt_q + 1'b1;
      if (mis) mis_cnt_d = (mis_cnt_q == '1) ? mis_cnt_q : mis_cnt_q + 1'b1;
      if (ovf_hit) ovf_d = 1'b1;
    end
    pass_d = (mis_cnt_d == '0) && (res_cnt_d == exp_cnt_q) && !ovf_d;
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wdog_q       <= '0;
      mem_rst_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      ovf_q        <= 1'b0;
      fail_seen_q  <= 1'b0;
      res_cnt_q    <= '0;
      mis_cnt_q    <= '0;
      ffi_q        <= '1;
      exp_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_go) begin
            state_q      <= S_MEM_RST;
            cnt_q        <= '0;
            mem_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            ovf_q        <= 1'b0;
            fail_seen_q  <= 1'b0;
            res_cnt_q    <= '0;
            mis_cnt_q    <= '0;
            ffi_q        <= '1;
            exp_cnt_q    <= i_exp_count;
          end
        end
        S_MEM_RST: begin
          if (cnt_q == 32'(MEM_RST_CYCLES - 1)) begin
            state_q      <= S_CORE_RST;
            cnt_q        <= '0;
            mem_rst_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CORE_RST: begin
          if (cnt_q == 32'(CORE_RST_CYCLES - 1)) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 32'(START_DELAY - 1)) begin
            state_q <= S_START;
            cnt_q   <= '0;
            start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_START: begin
          state_q <= S_RUN;
          start_q <= 1'b0;
          wdog_q  <= '0;
        end
        S_RUN: begin
          res_cnt_q <= res_cnt_d;
          mis_cnt_q <= mis_cnt_d;
          ovf_q     <= ovf_d;
          if (i_valid_result && mis && !fail_seen_q) begin
            ffi_q       <= res_cnt_q;
            fail_seen_q <= 1'b1;
          end
          // A result arriving with all_done is already folded into pass_d.
          if (i_all_done) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= pass_d;
          end else if (i_valid_result) begin
            wdog_q <= '0;
          end else if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_memory_reset   = mem_rst_q;
  assign o_core_reset_n   = core_rst_n_q;
  assign o_start          = start_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_pass           = pass_q;
  assign o_timeout        = timeout_q;
  assign o_overflow       = ovf_q;
  assign o_result_count   = res_cnt_q;
  assign o_mismatch_count = mis_cnt_q;
  assign o_first_fail_idx = ffi_q;

endmodule

// File: tb/tb_mest_pro_run_ctrl.sv
// Directed bench for mest_pro_run_ctrl: reset values, control pulse timing, watchdog,
// a table of result-checking scenarios, and a reset taken in the middle of a run.
module tb_mest_pro_run_ctrl;
  localparam int IDX_W = 8;
  localparam int DW    = 8;

  logic            clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic            i_go = 1'b0;
  logic            i_exp_wr = 1'b0;
  logic [IDX_W-1:0] i_exp_addr = '0;
  logic [DW+1:0]   i_exp_data = '0;
  logic [IDX_W:0]  i_exp_count = '0;
  logic            o_memory_reset, o_core_reset_n, o_start;
  logic [DW-1:0]   i_result = '0;
  logic            i_valid_result = 1'b0, i_carry = 1'b0, i_zero_flag = 1'b0, i_all_done = 1'b0;
  logic            o_busy, o_done, o_pass, o_timeout, o_overflow;
  logic [IDX_W:0]  o_result_count, o_mismatch_count, o_first_fail_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mest_pro_run_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_go(i_go),
    .i_exp_wr(i_exp_wr), .i_exp_addr(i_exp_addr), .i_exp_data(i_exp_data),
    .i_exp_count(i_exp_count),
    .o_memory_reset(o_memory_reset), .o_core_reset_n(o_core_reset_n), .o_start(o_start),
    .i_result(i_result), .i_valid_result(i_valid_result), .i_carry(i_carry),
    .i_zero_flag(i_zero_flag), .i_all_done(i_all_done),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_overflow(o_overflow), .o_result_count(o_result_count),
    .o_mismatch_count(o_mismatch_count), .o_first_fail_idx(o_first_fail_idx)
  );

  // Expected-table contents as {result, zero, carry}
  int er [8] = '{5, 0, 200, 60, 255, 1, 128, 17};
  bit ez [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
  bit ec [8] = '{0, 1, 0, 1, 1, 0, 0, 1};

  typedef struct {
    int exp_count;
    int n_results;
    int bad_idx;
    bit done_with_last;
    int e_rc;
    int e_mc;
    int e_ffi;
    bit e_pass;
    bit e_ovf;
  } scen_t;

  scen_t sv [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive_res(input int idx, input bit bad);
    i_valid_result = 1'b1;
    i_result       = 8'(er[idx]) ^ (bad ? 8'h07 : 8'h00);
    i_zero_flag    = ez[idx];
    i_carry        = ec[idx];
  endtask

  task automatic run_scen(input string nm, input scen_t s);
    bit ok;
    i_exp_count = 9'(s.exp_count);
    i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    wait_start(ok);
    chk({nm, ".start_seen"}, 32'(ok), 1);
    @(posedge clk); #1;
    for (int i = 0; i < s.n_results; i++) begin
      drive_res(i, i == s.bad_idx);
      i_all_done = s.done_with_last && (i == s.n_results - 1);
      @(posedge clk); #1;
    end
    i_valid_result = 1'b0;
    if (!(s.done_with_last && s.n_results > 0)) begin
      i_all_done = 1'b1;
      @(posedge clk); #1;
    end
    i_all_done = 1'b0;
    @(negedge clk);
    chk({nm, ".done"},     32'(o_done), 1);
    chk({nm, ".busy"},     32'(o_busy), 0);
    chk({nm, ".rc"},       32'(o_result_count), 32'(s.e_rc));
    chk({nm, ".mc"},       32'(o_mismatch_count), 32'(s.e_mc));
    chk({nm, ".ffi"},      32'(o_first_fail_idx), 32'(s.e_ffi));
    chk({nm, ".pass"},     32'(o_pass), 32'(s.e_pass));
    chk({nm, ".overflow"}, 32'(o_overflow), 32'(s.e_ovf));
    chk({nm, ".timeout"},  32'(o_timeout), 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, ".mem_rst"}, 32'(o_memory_reset), 0);
    chk({nm, ".core_n"},  32'(o_core_reset_n), 0);
    chk({nm, ".start"},   32'(o_start), 0);
    chk({nm, ".busy"},    32'(o_busy), 0);
    chk({nm, ".done"},    32'(o_done), 0);
    chk({nm, ".pass"},    32'(o_pass), 0);
    chk({nm, ".timeout"}, 32'(o_timeout), 0);
    chk({nm, ".ovf"},     32'(o_overflow), 0);
    chk({nm, ".rc"},      32'(o_result_count), 0);
    chk({nm, ".mc"},      32'(o_mismatch_count), 0);
    chk({nm, ".ffi"},     32'(o_first_fail_idx), 511);
  endtask

  initial begin
    bit ok;
    //            exp n  bad dwl rc mc ffi  pass ovf
    sv[0] = '{3, 3, -1, 0, 3, 0, 511, 1, 0};
    sv[1] = '{3, 3,  1, 0, 3, 1, 1,   0, 0};
    sv[2] = '{2, 3, -1, 1, 3, 1, 2,   0, 1};
    sv[3] = '{5, 5,  4, 1, 5, 1, 4,   0, 0};
    sv[4] = '{4, 2, -1, 0, 2, 0, 511, 0, 0};
    sv[5] = '{0, 0, -1, 0, 0, 0, 511, 1, 0};
    sv[6] = '{1, 3, -1, 0, 3, 2, 1,   0, 1};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    i_reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      i_exp_wr   = 1'b1;
      i_exp_addr = 8'(i);
      i_exp_data = {ec[i], ez[i], 8'(er[i])};
      @(posedge clk); #1;
    end
    i_exp_wr = 1'b0;

    // Pulse timing from go, then a silent core until the watchdog fires
    i_exp_count = 9'd3;
    i_go = 1'b1;
    @(negedge clk);
    chk("t0.mem_rst", 32'(o_memory_reset), 0);
    chk("t0.core_n",  32'(o_core_reset_n), 0);
    @(posedge clk); #1;
    i_go = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk($sformatf("t%0d.mem_rst", k), 32'(o_memory_reset), 32'(k == 1));
      chk($sformatf("t%0d.core_n", k),  32'(o_core_reset_n), 32'(!(k >= 2 && k <= 11)));
      chk($sformatf("t%0d.start", k),   32'(o_start), 32'(k == 22));
      chk($sformatf("t%0d.busy", k),    32'(o_busy), 32'(k <= 38));
      chk($sformatf("t%0d.done", k),    32'(o_done), 32'(k >= 39));
      chk($sformatf("t%0d.timeout", k), 32'(o_timeout), 32'(k >= 39));
      @(posedge clk); #1;
    end
    chk("tmo.pass", 32'(o_pass), 0);
    chk("tmo.rc",   32'(o_result_count), 0);

    for (int i = 0; i < 7; i++) run_scen($sformatf("scen%0d", i), sv[i]);

    // Reset taken mid-run, then a clean rerun from the retained table
    i_exp_count = 9'd3;
    i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    wait_start(ok);
    chk("midrst.start_seen", 32'(ok), 1);
    @(posedge clk); #1;
    drive_res(0, 1'b1);
    @(posedge clk); #1;
    i_valid_result = 1'b0;
    i_reset_n = 1'b0;
    @(negedge clk);
    chk("midrst.busy_before", 32'(o_busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    run_scen("rerun", sv[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mest_pro_run_ctrl.md
MEST_PRO_RUN_CTRL -- requirements
Module: mest_pro_run_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, core result width.
REQ-002 SHALL have parameter RESULT_DEPTH, default 256, expected-table entries (power of 2); IDX_W = clog2(RESULT_DEPTH).
REQ-003 SHALL have parameter MEM_RST_CYCLES, default 1, memory-reset pulse length.
REQ-004 SHALL have parameter CORE_RST_CYCLES, default 10, core reset hold length.
REQ-005 SHALL have parameter START_DELAY, default 10, cycles from core reset release to start.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum idle cycles in RUN.
REQ-007 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have port i_reset_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port i_go  input  1  start a run; sampled only in IDLE.
REQ-010 SHALL have ports i_exp_wr / i_exp_addr / i_exp_data  input  1 / IDX_W / DATA_WIDTH+2  expected-table write: {carry, zero, result}.
REQ-011 SHALL have port i_exp_count  input  IDX_W+1  number of results expected this run; latched on i_go.
REQ-012 SHALL have ports o_memory_reset, o_core_reset_n, o_start  output  1  core control.
REQ-013 SHALL have ports i_result / i_valid_result / i_carry / i_zero_flag / i_all_done  input  DATA_WIDTH / 1 / 1 / 1 / 1  core outputs.
REQ-014 SHALL have ports o_busy, o_done, o_pass, o_timeout, o_overflow  output  1  status.
REQ-015 SHALL have ports o_result_count, o_mismatch_count  output  IDX_W+1  counters (saturating).
REQ-016 SHALL have port o_first_fail_idx  output  IDX_W+1  index of first mismatch; all-ones when none.

Function
REQ-017 SHALL implement states IDLE, MEM_RST, CORE_RST, WAIT, START, RUN, DONE.
REQ-018 IDLE: i_go=1 -> MEM_RST; clear counters, flags, o_done; latch i_exp_count.
REQ-019 MEM_RST: o_memory_reset=1 for exactly MEM_RST_CYCLES cycles -> CORE_RST.
REQ-020 CORE_RST: o_core_reset_n=0 for exactly CORE_RST_CYCLES cycles -> WAIT; o_core_reset_n=1 in all other states except IDLE after reset (see REQ-029).
REQ-021 WAIT: START_DELAY cycles -> START; START: o_start=1 for exactly one cycle -> RUN.
REQ-022 RUN: each cycle with i_valid_result=1 compares {i_carry,i_zero_flag,i_result} to table[o_result_count]; mismatch increments o_mismatch_count; o_result_count increments; counts visible the cycle after the valid.
REQ-023 First mismatch SHALL record its index in o_first_fail_idx; later mismatches do not update it.
REQ-024 Valid result when o_result_count >= RESULT_DEPTH or >= latched expected count: counted as mismatch, o_overflow=1 (sticky), no table read.
REQ-025 i_all_done=1 in RUN -> DONE; if i_valid_result asserted same cycle, that result is checked and counted first.
REQ-026 Watchdog: counter reset on every i_valid_result; reaches TIMEOUT_CYCLES with no i_all_done -> o_timeout=1, DONE.
REQ-027 DONE: o_done=1, o_busy=0; o_pass=1 iff mismatch_count=0, result_count=latched expected count, o_timeout=0, o_overflow=0; holds until next i_go (DONE accepts i_go like IDLE).
REQ-028 o_busy=1 in MEM_RST through RUN; i_go ignored while busy; i_exp_wr accepted in any state (writes during RUN undefined for checking, not blocked).
REQ-029 Core control outputs registered; o_core_reset_n=0 in IDLE so the core is held until a run.

Reset
REQ-030 i_reset_n=0 at a clock edge SHALL force IDLE from any state, including mid-run: o_memory_reset=0, o_core_reset_n=0, o_start=0, all status 0, counters 0, o_first_fail_idx all-ones.
REQ-031 Expected table contents SHALL NOT be cleared by reset.

Verification
REQ-032 Defaults, table {5,0,0},{0,1,1},{200,0,0}, exp_count=3, core returns matching 3 results then all_done -> o_pass=1, result_count=3, mismatch_count=0, first_fail_idx=all-ones.
REQ-033 i_go at cycle 0 -> memory_reset high cycle 1 only, core_reset_n low cycles 2-11, start high cycle 22 only.
REQ-034 Result 1 returns 7 instead of 0 -> mismatch_count=1, first_fail_idx=1, o_pass=0.
REQ-035 TIMEOUT_CYCLES=16, core silent after start -> o_timeout=1 and o_done=1 exactly 16 cycles into RUN, o_pass=0.
REQ-036 exp_count=2, core returns 3 results with third coincident with all_done -> result_count=3, o_overflow=1, o_pass=0.
REQ-037 Reset asserted during RUN then i_go with same table -> clean second run reports o_pass=1.
